// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pipe_hazard_ctrl_if
// Brief    : Hazard-controller bundle: stage status in, hold/bubble/redirect out.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             if_busy;
  logic             mem_busy;
  logic             ex_busy;
  logic             load_stall;
  logic             error_pre;
  logic [1:0]       jumptype;
  logic             fence_i;
  logic [2:0]       down_valid;
  logic             inv_done;

  logic             stall_pc;
  logic             stall_ifid;
  logic             stall_idex;
  logic             stall_exmem;
  logic             bubble_ifid;
  logic             bubble_idex;
  logic             bubble_exmem;
  logic             bubble_memwb;
  logic             redirect;
  logic             fence_resume;
  logic             icache_inv;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] cnt_stall;
  logic [CNT_W-1:0] cnt_branch;
  logic [CNT_W-1:0] cnt_mispred;

  modport master (
    output if_busy, mem_busy, ex_busy, load_stall, error_pre, jumptype,
           fence_i, down_valid, inv_done,
    input  stall_pc, stall_ifid, stall_idex, stall_exmem,
           bubble_ifid, bubble_idex, bubble_exmem, bubble_memwb,
           redirect, fence_resume, icache_inv, ctrl_state,
           cnt_stall, cnt_branch, cnt_mispred
  );

  modport slave (
    input  if_busy, mem_busy, ex_busy, load_stall, error_pre, jumptype,
           fence_i, down_valid, inv_done,
    output stall_pc, stall_ifid, stall_idex, stall_exmem,
           bubble_ifid, bubble_idex, bubble_exmem, bubble_memwb,
           redirect, fence_resume, icache_inv, ctrl_state,
           cnt_stall, cnt_branch, cnt_mispred
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush/redirect scheduler for a 5-stage in-order pipeline.
// Revision : 1.0
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  wire logic            clock,
  input  wire logic            reset,
  pipe_hazard_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DISCARD = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_INV     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t r_state;
  state_t w_next;

  logic w_stall_pc;
  logic w_stall_ifid;
  logic w_stall_idex;
  logic w_stall_exmem;
  logic w_bubble_ifid;
  logic w_bubble_idex;
  logic w_bubble_exmem;
  logic w_bubble_memwb;
  logic w_redirect;
  logic w_fence_resume;
  logic w_icache_inv;

  logic [CNT_W-1:0] r_cnt_stall;
  logic [CNT_W-1:0] r_cnt_branch;
  logic [CNT_W-1:0] r_cnt_mispred;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_stall_pc     = 1'b0;
    w_stall_ifid   = 1'b0;
    w_stall_idex   = 1'b0;
    w_stall_exmem  = 1'b0;
    w_bubble_ifid  = 1'b0;
    w_bubble_idex  = 1'b0;
    w_bubble_exmem = 1'b0;
    w_bubble_memwb = 1'b0;
    w_redirect     = 1'b0;
    w_fence_resume = 1'b0;
    w_icache_inv   = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (bus.mem_busy) begin
          w_stall_pc     = 1'b1;
          w_stall_ifid   = 1'b1;
          w_stall_idex   = 1'b1;
          w_stall_exmem  = 1'b1;
          w_bubble_memwb = 1'b1;
        end else if (bus.ex_busy) begin
          w_stall_pc     = 1'b1;
          w_stall_ifid   = 1'b1;
          w_stall_idex   = 1'b1;
          w_bubble_exmem = 1'b1;
        end else if (bus.load_stall) begin
          // Branch operands are stale behind a load-use hazard; mispredict waits.
          w_stall_pc    = 1'b1;
          w_stall_ifid  = 1'b1;
          w_bubble_idex = 1'b1;
        end else if (bus.fence_i) begin
          w_stall_pc    = 1'b1;
          w_stall_ifid  = 1'b1;
          w_bubble_idex = 1'b1;
          w_next        = ST_DRAIN;
        end else if (bus.error_pre) begin
          w_redirect    = 1'b1;
          w_bubble_ifid = 1'b1;
          if (bus.if_busy) begin
            w_next = ST_DISCARD;
          end
        end else if (bus.if_busy) begin
          w_stall_pc    = 1'b1;
          w_bubble_ifid = 1'b1;
        end
      end

      ST_DISCARD: begin
        // The in-flight fetch is wrong-path: IF/ID is bubbled, never held.
        w_stall_pc    = 1'b1;
        w_bubble_ifid = 1'b1;
        if (bus.mem_busy) begin
          w_stall_idex   = 1'b1;
          w_stall_exmem  = 1'b1;
          w_bubble_memwb = 1'b1;
        end else if (bus.ex_busy) begin
          w_stall_idex   = 1'b1;
          w_bubble_exmem = 1'b1;
        end
        if (!bus.if_busy) begin
          w_next = ST_RUN;
        end
      end

      ST_DRAIN: begin
        w_stall_pc   = 1'b1;
        w_stall_ifid = 1'b1;
        if (bus.mem_busy) begin
          w_stall_idex   = 1'b1;
          w_stall_exmem  = 1'b1;
          w_bubble_memwb = 1'b1;
        end else if (bus.ex_busy) begin
          w_stall_idex   = 1'b1;
          w_bubble_exmem = 1'b1;
        end else begin
          w_bubble_idex = 1'b1;
        end
        if (bus.down_valid == 3'b000) begin
          w_next = ST_INV;
        end
      end

      ST_INV: begin
        w_icache_inv = 1'b1;
        if (bus.inv_done) begin
          w_fence_resume = 1'b1;
          w_bubble_ifid  = 1'b1;
          w_next         = ST_RUN;
        end else begin
          w_stall_pc    = 1'b1;
          w_stall_ifid  = 1'b1;
          w_bubble_idex = 1'b1;
        end
      end

      default: begin
        w_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt_stall   <= '0;
      r_cnt_branch  <= '0;
      r_cnt_mispred <= '0;
    end else begin
      if (w_stall_pc) begin
        r_cnt_stall <= r_cnt_stall + c_ONE;
      end
      if ((r_state == ST_RUN) && (bus.jumptype != 2'b00) && !w_stall_ifid) begin
        r_cnt_branch <= r_cnt_branch + c_ONE;
      end
      if ((r_state == ST_RUN) && w_redirect) begin
        r_cnt_mispred <= r_cnt_mispred + c_ONE;
      end
    end
  end

  assign bus.stall_pc     = w_stall_pc     & ~reset;
  assign bus.stall_ifid   = w_stall_ifid   & ~reset;
  assign bus.stall_idex   = w_stall_idex   & ~reset;
  assign bus.stall_exmem  = w_stall_exmem  & ~reset;
  assign bus.bubble_ifid  = w_bubble_ifid  & ~reset;
  assign bus.bubble_idex  = w_bubble_idex  & ~reset;
  assign bus.bubble_exmem = w_bubble_exmem & ~reset;
  assign bus.bubble_memwb = w_bubble_memwb & ~reset;
  assign bus.redirect     = w_redirect     & ~reset;
  assign bus.fence_resume = w_fence_resume & ~reset;
  assign bus.icache_inv   = w_icache_inv   & ~reset;
  assign bus.ctrl_state   = r_state;
  assign bus.cnt_stall    = r_cnt_stall;
  assign bus.cnt_branch   = r_cnt_branch;
  assign bus.cnt_mispred  = r_cnt_mispred;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_pipe_hazard_ctrl
// Brief    : Vector table, directed corner sequences and random run vs. model.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       if_busy;
    logic       mem_busy;
    logic       ex_busy;
    logic       load_stall;
    logic       error_pre;
    logic [1:0] jumptype;
    logic       fence_i;
    logic [2:0] down_valid;
    logic       inv_done;
  } stim_t;

  // ctrl word: {sp,si,sx,se, bi,bx,be,bm, redirect,fence_resume,icache_inv}
  typedef struct {
    stim_t       s;
    logic [10:0] exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  stim_t cur = '0;
  int n_checks = 0;
  int n_errors = 0;

  int              m_state;
  longint unsigned m_stall, m_branch, m_mispred;

  always #5 clock = ~clock;

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus32 ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus32.if_busy = cur.if_busy;       assign bus4.if_busy = cur.if_busy;
  assign bus32.mem_busy = cur.mem_busy;     assign bus4.mem_busy = cur.mem_busy;
  assign bus32.ex_busy = cur.ex_busy;       assign bus4.ex_busy = cur.ex_busy;
  assign bus32.load_stall = cur.load_stall; assign bus4.load_stall = cur.load_stall;
  assign bus32.error_pre = cur.error_pre;   assign bus4.error_pre = cur.error_pre;
  assign bus32.jumptype = cur.jumptype;     assign bus4.jumptype = cur.jumptype;
  assign bus32.fence_i = cur.fence_i;       assign bus4.fence_i = cur.fence_i;
  assign bus32.down_valid = cur.down_valid; assign bus4.down_valid = cur.down_valid;
  assign bus32.inv_done = cur.inv_done;     assign bus4.inv_done = cur.inv_done;

  pipe_hazard_ctrl #(.CNT_W(32)) u_dut32 (.clock(clock), .reset(reset), .bus(bus32.slave));
  pipe_hazard_ctrl #(.CNT_W(4))  u_dut4  (.clock(clock), .reset(reset), .bus(bus4.slave));

  function automatic logic [10:0] ctrl32();
    return {bus32.stall_pc, bus32.stall_ifid, bus32.stall_idex, bus32.stall_exmem,
            bus32.bubble_ifid, bus32.bubble_idex, bus32.bubble_exmem, bus32.bubble_memwb,
            bus32.redirect, bus32.fence_resume, bus32.icache_inv};
  endfunction

  function automatic logic [10:0] ctrl4();
    return {bus4.stall_pc, bus4.stall_ifid, bus4.stall_idex, bus4.stall_exmem,
            bus4.bubble_ifid, bus4.bubble_idex, bus4.bubble_exmem, bus4.bubble_memwb,
            bus4.redirect, bus4.fence_resume, bus4.icache_inv};
  endfunction

  // Model: every condition asks to hold the first k pipeline registers
  // (pc=0, ifid=1, idex=2, exmem=3) and to bubble the register just behind them.
  function automatic logic [10:0] model_ctrl(input int st, input stim_t s, output int nxt);
    int k, busy_k;
    bit bub_k, bub_ifid, force_pc, free_ifid, rd, fr, ic;
    logic [4:0] held, bubbled;
    k = 0; bub_k = 0; bub_ifid = 0; force_pc = 0; free_ifid = 0;
    rd = 0; fr = 0; ic = 0; nxt = st;
    busy_k = s.mem_busy ? 4 : (s.ex_busy ? 3 : 0);
    case (st)
      0: begin
        if (busy_k != 0)       begin k = busy_k; bub_k = 1; end
        else if (s.load_stall) begin k = 2; bub_k = 1; end
        else if (s.fence_i)    begin k = 2; bub_k = 1; nxt = 2; end
        else if (s.error_pre)  begin rd = 1; bub_ifid = 1; nxt = s.if_busy ? 1 : 0; end
        else if (s.if_busy)    begin k = 1; bub_k = 1; end
      end
      1: begin
        k = busy_k; bub_k = (busy_k != 0);
        force_pc = 1; free_ifid = 1; bub_ifid = 1;
        nxt = s.if_busy ? 1 : 0;
      end
      2: begin
        k = (busy_k > 2) ? busy_k : 2; bub_k = 1;
        nxt = (s.down_valid == 3'b000) ? 3 : 2;
      end
      default: begin
        ic = 1;
        if (s.inv_done) begin fr = 1; bub_ifid = 1; nxt = 0; end
        else begin k = 2; bub_k = 1; end
      end
    endcase
    for (int i = 0; i < 5; i++) held[i] = (i < k);
    bubbled = '0;
    if (bub_k) bubbled[k] = 1'b1;
    if (force_pc) held[0] = 1'b1;
    if (free_ifid) held[1] = 1'b0;
    if (bub_ifid) bubbled[1] = 1'b1;
    return {held[0], held[1], held[2], held[3],
            bubbled[1], bubbled[2], bubbled[3], bubbled[4], rd, fr, ic};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, ".cnt_stall"},   64'(bus32.cnt_stall),   64'(m_stall[31:0]));
    check({tag, ".cnt_branch"},  64'(bus32.cnt_branch),  64'(m_branch[31:0]));
    check({tag, ".cnt_mispred"}, 64'(bus32.cnt_mispred), 64'(m_mispred[31:0]));
    check({tag, ".cnt4_stall"},  64'(bus4.cnt_stall),    64'(m_stall[3:0]));
    check({tag, ".cnt4_branch"}, 64'(bus4.cnt_branch),   64'(m_branch[3:0]));
    check({tag, ".cnt4_mispr"},  64'(bus4.cnt_mispred),  64'(m_mispred[3:0]));
  endtask

  // Entered at a negedge; returns at the next negedge.
  task automatic cycle(input stim_t s, input bit use_c, input logic [10:0] c_ctrl,
                       input logic [1:0] c_state, input string tag);
    int nxt;
    logic [10:0] e;
    cur = s;
    #1;
    e = model_ctrl(m_state, s, nxt);
    check({tag, ".ctrl"},  64'(ctrl32()), 64'(e));
    check({tag, ".ctrl4"}, 64'(ctrl4()),  64'(e));
    check({tag, ".state"}, 64'(bus32.ctrl_state), 64'(m_state));
    check_counters(tag);
    if (use_c) begin
      check({tag, ".ctrl_ref"},  64'(ctrl32()), 64'(c_ctrl));
      check({tag, ".state_ref"}, 64'(bus32.ctrl_state), 64'(c_state));
    end
    @(posedge clock);
    if (e[10]) m_stall++;
    if (m_state == 0) begin
      if (s.jumptype != 2'b00 && !e[9]) m_branch++;
      if (e[2]) m_mispred++;
    end
    m_state = nxt;
    @(negedge clock);
  endtask

  // Asserted mid-phase so the asynchronous path is what clears the state.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check({tag, ".rst_ctrl"},  64'(ctrl32()), 64'd0);
    check({tag, ".rst_ctrl4"}, 64'(ctrl4()),  64'd0);
    check({tag, ".rst_state"}, 64'(bus32.ctrl_state), 64'd0);
    check({tag, ".rst_cnt"},   64'({bus32.cnt_stall, bus32.cnt_branch}), 64'd0);
    check({tag, ".rst_cnt_m"}, 64'(bus32.cnt_mispred), 64'd0);
    m_state = 0; m_stall = 0; m_branch = 0; m_mispred = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic stim_t mk(input logic ib, input logic mb, input logic eb,
                               input logic ls, input logic ep, input logic [1:0] jt,
                               input logic fi, input logic [2:0] dv, input logic id);
    stim_t s;
    s.if_busy = ib; s.mem_busy = mb; s.ex_busy = eb; s.load_stall = ls;
    s.error_pre = ep; s.jumptype = jt; s.fence_i = fi; s.down_valid = dv;
    s.inv_done = id;
    return s;
  endfunction

  vec_t tbl[8];
  stim_t s;

  initial begin
    m_state = 0; m_stall = 0; m_branch = 0; m_mispred = 0;

    //                     ib    mb    eb    ls    ep    jt     fi    dv      id
    tbl[0] = '{mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0), 11'b0000_0000_000};
    tbl[1] = '{mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 1'b0), 11'b1111_0001_000};
    tbl[2] = '{mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 3'b111, 1'b0), 11'b1110_0010_000};
    tbl[3] = '{mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 3'b000, 1'b0), 11'b1100_0100_000};
    tbl[4] = '{mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 3'b000, 1'b0), 11'b0000_1000_100};
    tbl[5] = '{mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0), 11'b1000_1000_000};
    tbl[6] = '{mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 3'b000, 1'b1), 11'b1100_0100_000};
    tbl[7] = '{mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 3'b000, 1'b0), 11'b1100_0100_000};

    do_reset("init");

    foreach (tbl[i]) cycle(tbl[i].s, 1'b1, tbl[i].exp, 2'd0, $sformatf("tbl%0d", i));

    // Load-use masks the mispredict for one cycle, then it is accepted.
    do_reset("lu");
    cycle(mk(0, 0, 0, 1, 1, 2'd0, 0, 3'b000, 0), 1'b1, 11'b1100_0100_000, 2'd0, "lu_both");
    check("lu.mispred_held", 64'(bus32.cnt_mispred), 64'd0);
    cycle(mk(0, 0, 0, 0, 1, 2'd0, 0, 3'b000, 0), 1'b1, 11'b0000_1000_100, 2'd0, "lu_err");
    check("lu.mispred_one", 64'(bus32.cnt_mispred), 64'd1);

    // Mispredict with fetch outstanding: discard the wrong-path fetch.
    do_reset("dis");
    cycle(mk(1, 0, 0, 0, 1, 2'd0, 0, 3'b000, 0), 1'b1, 11'b0000_1000_100, 2'd0, "dis_err");
    for (int i = 0; i < 3; i++)
      cycle(mk(1, 0, 0, 0, 1, 2'd0, 0, 3'b000, 0), 1'b1, 11'b1000_1000_000, 2'd1, "dis_busy");
    cycle(mk(0, 0, 0, 0, 0, 2'd0, 0, 3'b000, 0), 1'b1, 11'b1000_1000_000, 2'd1, "dis_ret");
    cycle(mk(0, 0, 0, 0, 0, 2'd0, 0, 3'b000, 0), 1'b1, 11'b0000_0000_000, 2'd0, "dis_run");
    check("dis.cnt_stall", 64'(bus32.cnt_stall), 64'd4);
    check("dis.cnt_mispred", 64'(bus32.cnt_mispred), 64'd1);

    // Memory and multi-cycle EX together: memory wins.
    do_reset("mx");
    for (int i = 0; i < 5; i++)
      cycle(mk(0, 1, 1, 0, 0, 2'd0, 0, 3'b111, 0), 1'b1, 11'b1111_0001_000, 2'd0, "mx");
    check("mx.cnt_stall", 64'(bus32.cnt_stall), 64'd5);

    // fence.i: drain, invalidate, resume.
    do_reset("fen");
    cycle(mk(0, 0, 0, 0, 0, 2'd0, 1, 3'b111, 0), 1'b1, 11'b1100_0100_000, 2'd0, "fen_run");
    cycle(mk(0, 0, 0, 0, 0, 2'd0, 0, 3'b111, 0), 1'b1, 11'b1100_0100_000, 2'd2, "fen_dr0");
    cycle(mk(0, 0, 0, 0, 0, 2'd0, 0, 3'b011, 1), 1'b1, 11'b1100_0100_000, 2'd2, "fen_dr1");
    cycle(mk(0, 0, 0, 0, 0, 2'd0, 0, 3'b000, 0), 1'b1, 11'b1100_0100_000, 2'd2, "fen_dr2");
    for (int i = 0; i < 4; i++)
      cycle(mk(0, 0, 0, 0, 0, 2'd0, 0, 3'b000, 0), 1'b1, 11'b1100_0100_001, 2'd3, "fen_inv");
    cycle(mk(0, 0, 0, 0, 0, 2'd0, 0, 3'b000, 1), 1'b1, 11'b0000_1000_011, 2'd3, "fen_done");
    cycle(mk(0, 0, 0, 0, 0, 2'd0, 0, 3'b000, 0), 1'b1, 11'b0000_0000_000, 2'd0, "fen_back");

    // Reset in the middle of the invalidate phase.
    cycle(mk(0, 0, 0, 0, 0, 2'd0, 1, 3'b000, 0), 1'b1, 11'b1100_0100_000, 2'd0, "ri_run");
    cycle(mk(0, 0, 0, 0, 0, 2'd0, 0, 3'b000, 0), 1'b1, 11'b1100_0100_000, 2'd2, "ri_drain");
    cycle(mk(0, 0, 0, 0, 0, 2'd0, 0, 3'b000, 0), 1'b1, 11'b1100_0100_001, 2'd3, "ri_inv");
    do_reset("ri");

    // 17 accepted branches wrap a 4-bit counter to 1.
    for (int i = 0; i < 17; i++)
      cycle(mk(0, 0, 0, 0, 0, 2'd1, 0, 3'b000, 0), 1'b1, 11'b0000_0000_000, 2'd0, "br");
    check("br.cnt4", 64'(bus4.cnt_branch), 64'd1);
    check("br.cnt32", 64'(bus32.cnt_branch), 64'd17);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset("rnd");
      s.if_busy    = ($urandom_range(0, 2) == 0);
      s.mem_busy   = ($urandom_range(0, 5) == 0);
      s.ex_busy    = ($urandom_range(0, 4) == 0);
      s.load_stall = ($urandom_range(0, 4) == 0);
      s.error_pre  = ($urandom_range(0, 3) == 0);
      s.jumptype   = 2'($urandom_range(0, 3));
      s.fence_i    = ($urandom_range(0, 15) == 0);
      s.down_valid = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      s.inv_done   = ($urandom_range(0, 3) == 0);
      cycle(s, 1'b0, 11'b0, 2'd0, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
